// File: rtl/mem_access_m.sv
// mem_access_m
//   Memory-stage load/store unit. Converts an M-stage load or store into a
//   single request/ready data-memory transaction. It builds byte enables and
//   lane-replicated store data, and returns the load word right-aligned on RD.
//   It holds StallM until the bus completes the transfer or the transfer
//   times out.
//
//   Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half and
//   word accesses on MisalignM instead of issuing them. When the macro is not
//   defined, MisalignM is tied low and a misaligned access goes to the
//   aligned-down lane.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   ResultSrcM          2'b01 marks a load
//   MemWriteM           store request (takes priority over a load)
//   ALUResultM          effective byte address
//   WriteDataM          store data, low lanes valid
//   funct3M             access size in [1:0]
//   mem_req/we/addr/wdata/be   registered bus request
//   mem_ready/mem_rdata transfer completion and read word
//   RD                  right-aligned load word to the MEM/WB register
//   StallM              pipeline freeze (combinational)
//   BusErrM             one-cycle timeout flag
//   MisalignM           misaligned-access flag (combinational)
//
// States
//   IDLE | waiting for an access; launches the bus request
//   BUSY | request outstanding; waits for mem_ready or timeout
//   DONE | one non-stalled cycle so the pipeline advances once
module mem_access_m #(
  parameter int DATA_WIDTH     = 32,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [1:0]              ResultSrcM,
  input  logic                    MemWriteM,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [FUNCT3_WIDTH-1:0] funct3M,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    StallM,
  output logic                    BusErrM,
  output logic                    MisalignM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q;
  logic [15:0]             cnt_q;
  logic [1:0]              off_q;
  logic                    load_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [3:0]              mem_be_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    bus_err_q;

  logic                    is_load_d;
  logic                    access_d;
  logic                    mis_d;
  logic [1:0]              off_d;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d;

  // funct3M[2] selects signedness, which is handled later in W.
  logic unused_f3;
  assign unused_f3 = funct3M[FUNCT3_WIDTH-1];

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Access decode. A half ignores addr[0] and a word ignores addr[1:0], so an
  // access that is not trapped uses the aligned-down lane.
  always_comb begin
    access_d  = MemWriteM | (ResultSrcM == 2'b01);
    is_load_d = (ResultSrcM == 2'b01) & ~MemWriteM;
    off_d     = 2'b00;
    be_d      = 4'b1111;
    wdata_d   = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        off_d   = ALUResultM[1:0];
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        off_d   = {ALUResultM[1], 1'b0};
        be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: begin
        off_d   = 2'b00;
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    mis_d = 1'b0;
    if (access_d) begin
      case (funct3M[1:0])
        2'b00:   mis_d = 1'b0;
        2'b01:   mis_d = ALUResultM[0];
        default: mis_d = |ALUResultM[1:0];
      endcase
    end
  end
`else
  assign mis_d = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rd_q        <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_d && !mis_d) begin
            mem_addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            mem_we_q    <= MemWriteM;
            off_q       <= off_d;
            load_q      <= is_load_d;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // Completion has priority over a timeout in the same cycle.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (load_q) rd_q <= mem_rdata >> {off_q, 3'b000};
            state_q   <= DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            mem_req_q <= 1'b0;
            if (load_q) rd_q <= '0;
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          bus_err_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign RD        = rd_q;
  assign BusErrM   = bus_err_q;
  assign StallM    = ((state_q == IDLE) && access_d && !mis_d) || (state_q == BUSY);
  assign MisalignM = (state_q == IDLE) && mis_d;

endmodule

// File: tb/tb_mem_access_m.sv
module tb_mem_access_m;
  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [2:0]  funct3M = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] RD;
  logic        StallM, BusErrM, MisalignM;

  mem_access_m #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST_N(RST_N), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .RD(RD),
    .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        berr;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transaction ends on the first non-stalled cycle after stalls.
  int          stall_cnt = 0;
  bit          bus_seen = 0;
  bit          chk_clear = 0;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;

  always @(negedge CLK) begin
    if (!RST_N) begin
      stall_cnt = 0;
      bus_seen  = 0;
      chk_clear = 0;
    end else begin
      if (chk_clear) begin
        chk("buserr_clear", {31'd0, BusErrM}, 32'd0);
        chk_clear = 0;
      end
      if (mem_req && !bus_seen) begin
        c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be;
        bus_seen = 1;
      end
      if (StallM) stall_cnt++;
      else if (stall_cnt > 0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = q.pop_front();
          chk("bus_seen", {31'd0, bus_seen}, 32'd1);
          chk("mem_we", {31'd0, c_we}, {31'd0, e.we});
          chk("mem_addr", c_addr, e.addr);
          chk("mem_be", {28'd0, c_be}, {28'd0, e.be});
          chk("mem_wdata", c_wdata, e.wdata);
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("buserr", {31'd0, BusErrM}, {31'd0, e.berr});
          chk("rd", RD, e.rd);
          chk("req_dropped", {31'd0, mem_req}, 32'd0);
        end
        stall_cnt = 0;
        bus_seen  = 0;
        chk_clear = 1;
      end
    end
  end

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic set_nop();
    ResultSrcM = 2'($urandom_range(0, 3));
    if (ResultSrcM == 2'b01) ResultSrcM = 2'b10;
    MemWriteM  = 1'b0;
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    funct3M    = 3'($urandom);
  endtask

  task automatic do_access(input logic [1:0] rs, input logic mw, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3, input int w,
                           input logic [31:0] rdata);
    int n, lane, off, bi;
    bit seen, done, mis;
    exp_t x;
    n    = size_bytes(f3);
    lane = int'(addr % 4);
    off  = lane - (lane % n);
    mis  = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (lane % n) != 0;
`endif
    @(posedge CLK); #1;
    ResultSrcM = rs; MemWriteM = mw; ALUResultM = addr; WriteDataM = wd; funct3M = f3;
    mem_rdata  = rdata;
    mem_ready  = 1'($urandom);
    if (mis) begin
      @(negedge CLK);
      chk("misalign_flag", {31'd0, MisalignM}, 32'd1);
      chk("misalign_nostall", {31'd0, StallM}, 32'd0);
      @(posedge CLK); #1;
      chk("misalign_noreq", {31'd0, mem_req}, 32'd0);
      chk("misalign_rd", RD, rd_model);
      set_nop();
      return;
    end
    x.we    = mw;
    x.addr  = addr & 32'hFFFF_FFFC;
    x.be    = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) x.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    x.berr  = (w >= T);
    x.stalls = 1 + ((w < T) ? (w + 1) : T);
    if (rs == 2'b01 && !mw) rd_model = x.berr ? 32'd0 : (rdata >> (8 * off));
    x.rd    = rd_model;
    q.push_back(x);
    bi = 0; seen = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge CLK); #1;
      if (mem_req) begin
        mem_ready = (bi == w);
        bi++;
        seen = 1;
      end else if (seen) begin
        done = 1;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        set_nop();
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got no completion expected completion within 64 cycles");
    end
  endtask

  task automatic nop_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge CLK); #1;
      set_nop();
      mem_ready = 1'($urandom);
      @(negedge CLK);
      chk("nop_nostall", {31'd0, StallM}, 32'd0);
      chk("nop_noreq", {31'd0, mem_req}, 32'd0);
    end
  endtask

  initial begin
    int kind, w;
    logic [1:0] rs;
    logic mw;
    logic [2:0] f3;
    bit got;

    repeat (2) @(negedge CLK);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rd", RD, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    do_access(2'b00, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, 32'h0);
    do_access(2'b00, 1'b1, 32'h103, 32'h0000_00A5, 3'b000, 1, 32'h0);
    do_access(2'b01, 1'b0, 32'h202, 32'h0,         3'b001, 3, 32'h8001_7FFF);
    nop_cycles(2);
    do_access(2'b01, 1'b0, 32'h400, 32'h0,         3'b010, 10, 32'h1234_5678);
    do_access(2'b01, 1'b0, 32'h501, 32'h0,         3'b100, T - 1, 32'h1122_3344);
    do_access(2'b01, 1'b0, 32'h301, 32'h0,         3'b010, 0, 32'hCAFE_F00D);
    do_access(2'b01, 1'b1, 32'h602, 32'h0000_BEEF, 3'b001, 0, 32'h5555_5555);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom);
      case (kind)
        0: begin rs = 2'b01; mw = 1'b0; w = $urandom_range(0, T + 1); end
        1: begin rs = 2'($urandom); mw = 1'b1; w = $urandom_range(0, T - 1); end
        default: begin rs = 2'b01; mw = 1'b1; w = $urandom_range(0, T - 1); end
      endcase
      do_access(rs, mw, $urandom, $urandom, f3, w, $urandom);
      if ($urandom_range(0, 3) == 0) nop_cycles($urandom_range(1, 2));
    end

    // Reset while a load is outstanding in BUSY.
    @(posedge CLK); #1;
    ResultSrcM = 2'b01; MemWriteM = 1'b0; ALUResultM = 32'h40; funct3M = 3'b010;
    mem_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge CLK); #1;
      got = mem_req;
    end
    chk("rst_test_req_up", {31'd0, got}, 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    set_nop();
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, StallM}, 32'd0);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_be", {28'd0, mem_be}, 32'd0);
    chk("midrst_rd", RD, 32'd0);
    chk("midrst_berr", {31'd0, BusErrM}, 32'd0);
    chk("midrst_mis", {31'd0, MisalignM}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rd_model = '0;
    do_access(2'b01, 1'b0, 32'h704, 32'h0, 3'b010, 1, 32'h0BAD_F00D);
    nop_cycles(2);

    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_m.md
# mem_access_m

Memory-stage load/store unit of the pipelined RISC-V core, sitting between the EX/MEM pipeline register and the MEM/WB register (`reg_file_w`), whose `RD` input it drives. It turns M-stage load/store requests into a request/ready data-memory bus transaction. It generates byte enables and lane-replicated store data, and returns the load word right-aligned. It stalls the pipeline until the transaction completes or times out.

## Interface
- `DATA_WIDTH`, 32: data and address width; fixed at 32.
- `FUNCT3_WIDTH`, 3: width of `funct3M`.
- `TIMEOUT_CYCLES`, 255: maximum `BUSY` cycles without `mem_ready` before abort; range 1..65535.
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `ResultSrcM`  in  2  `2'b01` marks a load.
- `MemWriteM`  in  1  store request.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data, valid in low lanes.
- `funct3M`  in  3  access size/sign.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  write strobe, valid with `mem_req`.
- `mem_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ready`  in  1  transaction complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `RD`  out  32  load data to the MEM/WB register, shifted right by the byte offset.
- `StallM`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `BusErrM`  out  1  one-cycle timeout flag.
- `MisalignM`  out  1  misaligned-access flag; tied 0 without the macro.

## Operation
- The access is `load = (ResultSrcM==2'b01)` or `store = MemWriteM`. If both are set, the store wins.
- Size is decoded from `funct3M[1:0]`: 00 byte, 01 half, 10 word. Code 11 is treated as word.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `addr[1] ? 4'b1100 : 4'b0011`; word `4'b1111`.
- Store data: byte `{4{wd[7:0]}}`; half `{2{wd[15:0]}}`; word `wd`.
- The FSM has three states: `IDLE`, `BUSY`, `DONE`.
- `IDLE`:
  - On an aligned access, register `mem_addr`, `mem_be`, `mem_wdata`, `mem_we` and the byte offset, set `mem_req`, then go to `BUSY`.
  - With no access, stay in `IDLE`.
- `BUSY`:
  - `mem_req` is held high and the bus outputs are stable.
  - When `mem_ready` is high, clear `mem_req` and go to `DONE`. For a load, capture `RD <= mem_rdata >> (8*offset)` with zero fill.
  - When the timeout counter reaches `TIMEOUT_CYCLES`, clear `mem_req`, set `RD <= 0` and `BusErrM <= 1`, then go to `DONE`.
  - The timeout counter is 16 bits. It clears on entry to `BUSY` and increments each cycle in `BUSY`.
- `DONE`: unconditionally return to `IDLE`. `BusErrM` clears on leaving `DONE`.
- `StallM = (IDLE & access & ~misaligned) | BUSY`. `StallM` is low in `DONE`, so the pipeline advances exactly once per access.
- `RD` holds its last value for non-load instructions and for stores.
- Sign and zero extension are not done here; they happen in W from `funct3W`.

## Timing
- Reset values: `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_be` 0, `RD` 0, `BusErrM` 0, `MisalignM` 0; state `IDLE`; counter 0.
- `StallM` and `MisalignM` are combinational. All other outputs are registered.
- Best-case load/store with `mem_ready` on the first `BUSY` cycle:
  - cycle 0: `IDLE`, stall;
  - cycle 1: `BUSY`, stall;
  - cycle 2: `DONE`, no stall.
  - The MEM/WB register captures `RD` at the end of cycle 2.
- Each cycle `mem_ready` is late adds one stall cycle.
- `mem_ready` is ignored in `IDLE` and `DONE`.
- If `mem_ready` is high in the same cycle the timeout is reached, `mem_ready` wins: normal completion, no `BusErrM`.
- Reset asserted mid-transaction immediately forces `IDLE` and drops `mem_req`; the transaction is abandoned.
- The `RD` shift uses only `offset[1:0]`; there is no wrap into the adjacent word.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half with `addr[0]=1`, or a word with `addr[1:0]!=0`, is misaligned.
  - In `IDLE`, a misaligned access raises `MisalignM` combinationally while it is presented.
  - No bus request is made, `StallM` stays low and `RD` is unchanged.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `MisalignM` is tied 0.
  - A misaligned half ignores `addr[0]`, and a misaligned word ignores `addr[1:0]`.
  - The access proceeds at the aligned-down lane.

## Test plan
- Reset with outputs driven, `RST_N`=0 in `BUSY`: `mem_req`=0 and state `IDLE` in the same cycle; all outputs 0.
- SW to `0x100` with data `0xDEADBEEF`, ready on the first `BUSY` cycle: `mem_addr`=0x100, `mem_be`=4'b1111, `mem_wdata`=0xDEADBEEF, `mem_we`=1; `StallM` high for 2 cycles.
- SB to `0x103` with data `0x000000A5`: `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5.
- LH from `0x202` with `mem_rdata`=0x8001_7FFF, ready after 3 wait cycles: `RD`=0x00008001; `StallM` high for 5 cycles.
- Load with `mem_ready` never asserted and `TIMEOUT_CYCLES`=4: `BusErrM` pulses for 1 cycle, `RD`=0, `mem_req` drops, pipeline resumes.
- LW from `0x301`:
  - with `MEM_MISALIGN_TRAP_EN`: `MisalignM`=1, `mem_req` stays 0, no stall.
  - without the macro: `mem_addr`=0x300, `mem_be`=4'b1111, normal load.
